mem_req_queue: RTL
==================

Name: mem_req_queue

Overview:
- Parametrised load/store request queue between the EXE stage and the DCache. It replaces the single-shot, stall-until-data_ok access path with a FIFO of up to DEPTH pending requests plus up to MAX_OUT issued-but-unanswered requests.
- It performs store lane formatting (wstrb/wdata for sb/sh/sw/swl/swr) and address-error detection at enqueue.
- Flush discards queued requests and silently drains in-flight ones.

Parameters:
DEPTH, 4, queue entries; power of two, >=2
MAX_OUT, 2, max requests issued to DCache awaiting data_ok; 1..DEPTH
ADDR_W, 32, address width; tag = ADDR_W-12 bits

Ports:
clk  in  1  clock
resetn  in  1  reset, asynchronous, active-low
flush  in  1  exception/eret flush, one-cycle pulse
in_valid  in  1  EXE presents a memory request
in_ready  out  1  queue can accept this cycle
in_op  in  1  0 load, 1 store
in_size  in  2  0 byte, 1 half, 2 word
in_lr  in  2  00 normal, 01 left (lwl/swl), 10 right (lwr/swr)
in_addr  in  ADDR_W  effective address
in_wdata  in  32  raw rt value
in_ex  out  1  address error on current request (comb)
in_excode  out  5  `AdEL (load) / `AdES (store) when in_ex
data_valid  out  1  DCache request valid
data_op  out  1  0 read, 1 write
data_tag  out  ADDR_W-12  addr[ADDR_W-1:12]
data_index  out  8  addr[11:4]
data_offset  out  4  addr[3:0]
data_wstrb  out  4  byte enables (0000 for loads)
data_wdata  out  32  lane-aligned store data
data_addr_ok  in  1  DCache accepts request
data_data_ok  in  1  DCache completes oldest issued request
rsp_valid  out  1  response to MEM stage
rsp_op  out  1  op of completing request
busy  out  1  queue non-empty or requests in flight

Behaviour:
- Reset (resetn low, async): queue empty, rd/wr ptr 0, out_cnt 0, drop_cnt 0. All outputs 0 except busy 0 and in_ready 1 after deassert.
- Address error (comb, valid only with in_valid):
  - half with addr[0]!=0 -> error; word with in_lr==00 and addr[1:0]!=0 -> error; byte, lwl/lwr/swl/swr never error.
  - in_excode = `AdES if in_op else `AdEL. Erroneous requests are never enqueued.
- in_ready = !full && !flush.
- Enqueue when in_valid && in_ready && !in_ex. Stores are formatted at enqueue and held in the entry (op, addr, wstrb, wdata):
  - sb: wdata={4{rt[7:0]}}, wstrb=0001<<addr[1:0].
  - sh: wdata={2{rt[15:0]}}, wstrb=0011 (addr[1]=0) or 1100.
  - sw: wdata=rt, wstrb=1111.
  - swl, addr[1:0]=0/1/2/3: wdata=rt>>24/16/8/0, wstrb=0001/0011/0111/1111.
  - swr, addr[1:0]=0/1/2/3: wdata=rt<<0/8/16/24, wstrb=1111/1110/1100/1000.
- Issue:
  - data_valid = !empty && out_cnt<MAX_OUT && !flush. Address and data come from the head entry.
  - Head pops on data_valid && data_addr_ok, and out_cnt increments the same cycle.
  - Outputs hold stable while data_valid is high and addr_ok is low.
- Completion:
  - data_data_ok decrements out_cnt.
  - If drop_cnt>0, drop_cnt decrements and rsp_valid stays 0. Otherwise rsp_valid=1 (comb, same cycle) with rsp_op of the oldest issued entry, held in a MAX_OUT-deep op shift register.
  - Simultaneous issue and data_ok: out_cnt unchanged.
- Flush:
  - All queued entries are discarded next edge (ptrs equalised, count 0). No issue occurs in the flush cycle.
  - drop_cnt <= out_cnt, net of a data_ok in the same cycle; that data_ok is itself suppressed.
  - Enqueue is refused in the flush cycle.
- Full: count==DEPTH -> in_ready=0. Pointers wrap modulo DEPTH. Enqueue and pop in the same cycle on a full queue are allowed only via pop first; in_ready stays 0 when full, so no bypass.
- Empty: no bypass; minimum latency in_valid -> data_valid is 1 cycle.
- busy = count!=0 || out_cnt!=0.

Decomposition:
- Shared package/defines (global_defines.vh): `AdEL, `AdES, size/lr encodings, MEMQ_OP_LOAD/STORE.
- One sub-module, store_fmt: combinational lane formatter (size, lr, addr[1:0], rt -> wstrb, wdata), reused later by the uncached path.
- FIFO storage stays inline.

Test Plan:
- sw addr 0x1000_0004, rt 0xA1B2C3D4, addr_ok=1 -> next cycle data_valid, tag 0x10000, index 0x00, offset 0x4, wstrb 1111, wdata A1B2C3D4; data_ok 2 cycles later -> rsp_valid=1, rsp_op=1.
- swl addr ..._0001, rt 0x11223344 -> wstrb 0011, wdata 0x00001122; swr addr ..._0002 -> wstrb 1100, wdata 0x33440000; sb addr ..._0003 -> wstrb 1000, wdata 0x44444444.
- lh addr 0x...3 -> in_ex=1, in_excode=`AdEL, nothing enqueued; sw addr 0x...2 -> `AdES.
- Hold data_addr_ok=0, push DEPTH=4 loads -> in_ready drops after 4th; data_valid and address stable throughout; release -> 4 in-order issues, out_cnt never exceeds 2.
- Flush with 3 queued and 2 in flight -> queue empty next cycle, next 2 data_ok give rsp_valid=0, the third data_ok response (new request) gives rsp_valid=1.
- Assert resetn=0 mid-transfer asynchronously -> data_valid and rsp_valid drop immediately, busy=0, in_ready=1 after release.

Source files
------------

// File: rtl/mem_req_queue_pkg.sv
// Shared types and constants for the load/store request queue and its
// store lane formatter: exception codes, access size and left/right encodings.
package mem_req_queue_pkg;

  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;

  localparam logic MEMQ_OP_LOAD  = 1'b0;
  localparam logic MEMQ_OP_STORE = 1'b1;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } mem_size_e;

  typedef enum logic [1:0] {
    LR_NONE  = 2'b00,
    LR_LEFT  = 2'b01,
    LR_RIGHT = 2'b10
  } mem_lr_e;

  // Misalignment rule: halves need addr[0]==0, plain words need addr[1:0]==0,
  // bytes and the unaligned left/right word forms can never fault.
  function automatic logic addr_error(input logic [1:0] size,
                                      input logic [1:0] lr,
                                      input logic [1:0] addr_lo);
    logic err;
    err = 1'b0;
    if (size == SIZE_HALF && addr_lo[0]) begin
      err = 1'b1;
    end else if (size == SIZE_WORD && lr == LR_NONE && addr_lo != 2'b00) begin
      err = 1'b1;
    end
    return err;
  endfunction

endpackage

// File: rtl/mem_req_queue_if.sv
// Bundle of the EXE-side request port, the DCache request/response port and
// the MEM-side response. The slave view belongs to the queue, the master view
// to whatever drives it (pipeline and cache).
interface mem_req_queue_if #(
  parameter int ADDR_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic              in_op;
  logic [1:0]        in_size;
  logic [1:0]        in_lr;
  logic [ADDR_W-1:0] in_addr;
  logic [31:0]       in_wdata;
  logic              in_ex;
  logic [4:0]        in_excode;

  logic              data_valid;
  logic              data_op;
  logic [ADDR_W-13:0] data_tag;
  logic [7:0]        data_index;
  logic [3:0]        data_offset;
  logic [3:0]        data_wstrb;
  logic [31:0]       data_wdata;
  logic              data_addr_ok;
  logic              data_data_ok;

  logic              rsp_valid;
  logic              rsp_op;

  modport slave (
    input  in_valid, in_op, in_size, in_lr, in_addr, in_wdata,
    output in_ready, in_ex, in_excode,
    output data_valid, data_op, data_tag, data_index, data_offset,
    output data_wstrb, data_wdata,
    input  data_addr_ok, data_data_ok,
    output rsp_valid, rsp_op
  );

  modport master (
    output in_valid, in_op, in_size, in_lr, in_addr, in_wdata,
    input  in_ready, in_ex, in_excode,
    input  data_valid, data_op, data_tag, data_index, data_offset,
    input  data_wstrb, data_wdata,
    output data_addr_ok, data_data_ok,
    input  rsp_valid, rsp_op
  );

endinterface

// File: rtl/mem_req_queue_store_fmt.sv
// Combinational store lane formatter: turns a raw rt value plus size,
// left/right mode and the low address bits into byte enables and lane-aligned
// write data. Kept standalone so the uncached path can share it.
module store_fmt
  import mem_req_queue_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  lr_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] rt_i,
  output logic [3:0]  wstrb_o,
  output logic [31:0] wdata_o
);

  // swl moves the top bytes of rt down to the addressed lane, swr moves the
  // low bytes up; otherwise the value is replicated across lanes by size.
  always_comb begin
    wstrb_o = 4'b1111;
    wdata_o = rt_i;
    if (lr_i == LR_LEFT) begin
      wdata_o = rt_i >> {~addr_lo_i, 3'b000};
      wstrb_o = 4'b1111 >> ~addr_lo_i;
    end else if (lr_i == LR_RIGHT) begin
      wdata_o = rt_i << {addr_lo_i, 3'b000};
      wstrb_o = 4'b1111 << addr_lo_i;
    end else if (size_i == SIZE_BYTE) begin
      wdata_o = {4{rt_i[7:0]}};
      wstrb_o = 4'b0001 << addr_lo_i;
    end else if (size_i == SIZE_HALF) begin
      wdata_o = {2{rt_i[15:0]}};
      wstrb_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
    end
  end

endmodule

// File: rtl/mem_req_queue.sv
// Load/store request queue between EXE and the DCache. Requests are checked
// for alignment and formatted on entry, held in a small FIFO, issued in order
// with a cap on unanswered requests, and matched to data_ok responses. A flush
// empties the FIFO and silently swallows the responses of requests already
// sent to the cache.
module mem_req_queue
  import mem_req_queue_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int MAX_OUT = 2,
  parameter int ADDR_W  = 32
) (
  input  logic clk,
  input  logic resetn,
  input  logic flush,
  output logic busy,
  mem_req_queue_if.slave bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = $clog2(MAX_OUT + 1);
  localparam int SW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

  typedef struct packed {
    logic              op;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        wstrb;
    logic [31:0]       wdata;
  } entry_t;

  entry_t        fifo_q [DEPTH];
  entry_t        new_entry;
  entry_t        head;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [OW-1:0] out_cnt_q, out_cnt_d;
  logic [OW-1:0] drop_cnt_q, drop_cnt_d;
  logic          rsp_op_q [MAX_OUT];
  logic          rsp_op_d [MAX_OUT];
  logic [SW-1:0] slot;
  logic [3:0]    fmt_wstrb;
  logic [31:0]   fmt_wdata;
  logic          req_err, full, empty, enq, issue, complete;

  store_fmt u_store_fmt (
    .size_i    (bus.in_size),
    .lr_i      (bus.in_lr),
    .addr_lo_i (bus.in_addr[1:0]),
    .rt_i      (bus.in_wdata),
    .wstrb_o   (fmt_wstrb),
    .wdata_o   (fmt_wdata)
  );

  assign req_err       = addr_error(bus.in_size, bus.in_lr, bus.in_addr[1:0]);
  assign bus.in_ex     = bus.in_valid && req_err;
  assign bus.in_excode = bus.in_ex ? (bus.in_op ? EXC_ADES : EXC_ADEL) : 5'd0;

  assign full         = (count_q == CW'(DEPTH));
  assign empty        = (count_q == '0);
  assign bus.in_ready = !full && !flush;
  assign enq          = bus.in_valid && bus.in_ready && !req_err;

  assign new_entry.op    = bus.in_op;
  assign new_entry.addr  = bus.in_addr;
  assign new_entry.wstrb = (bus.in_op == MEMQ_OP_STORE) ? fmt_wstrb : 4'b0000;
  assign new_entry.wdata = (bus.in_op == MEMQ_OP_STORE) ? fmt_wdata : 32'd0;

  assign head            = fifo_q[rd_ptr_q];
  assign bus.data_valid  = !empty && (out_cnt_q < OW'(MAX_OUT)) && !flush;
  assign bus.data_op     = head.op;
  assign bus.data_tag    = head.addr[ADDR_W-1:12];
  assign bus.data_index  = head.addr[11:4];
  assign bus.data_offset = head.addr[3:0];
  assign bus.data_wstrb  = head.wstrb;
  assign bus.data_wdata  = head.wdata;

  assign issue    = bus.data_valid && bus.data_addr_ok;
  assign complete = bus.data_data_ok && (out_cnt_q != '0);

  assign bus.rsp_valid = complete && (drop_cnt_q == '0) && !flush;
  assign bus.rsp_op    = rsp_op_q[0];

  assign busy = !empty || (out_cnt_q != '0);

  // FIFO pointer and occupancy update; a flush collapses the queue by
  // pulling the read pointer up to the write pointer.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      if (enq) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (issue) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      if (enq && !issue) begin
        count_d = count_q + CW'(1);
      end else if (!enq && issue) begin
        count_d = count_q - CW'(1);
      end
    end
  end

  // In-flight bookkeeping: outstanding count, responses still to be swallowed
  // after a flush, and the op of each issued request in age order.
  always_comb begin
    out_cnt_d  = out_cnt_q;
    drop_cnt_d = drop_cnt_q;
    rsp_op_d   = rsp_op_q;
    slot       = SW'(out_cnt_q) - SW'(complete);
    if (issue && !complete) begin
      out_cnt_d = out_cnt_q + OW'(1);
    end else if (!issue && complete) begin
      out_cnt_d = out_cnt_q - OW'(1);
    end
    if (flush) begin
      drop_cnt_d = complete ? (out_cnt_q - OW'(1)) : out_cnt_q;
    end else if (complete && (drop_cnt_q != '0)) begin
      drop_cnt_d = drop_cnt_q - OW'(1);
    end
    if (complete) begin
      for (int i = 0; i < MAX_OUT - 1; i++) begin
        rsp_op_d[i] = rsp_op_q[i + 1];
      end
    end
    if (issue) begin
      rsp_op_d[slot] = head.op;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      out_cnt_q  <= '0;
      drop_cnt_q <= '0;
      for (int i = 0; i < MAX_OUT; i++) begin
        rsp_op_q[i] <= 1'b0;
      end
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      out_cnt_q  <= out_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      for (int i = 0; i < MAX_OUT; i++) begin
        rsp_op_q[i] <= rsp_op_d[i];
      end
    end
  end

  // Entry storage, written with the already formatted request on enqueue.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
    end else if (enq) begin
      fifo_q[wr_ptr_q] <= new_entry;
    end
  end

endmodule
